dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 256x16 data memory between the CPU control unit (Store/Load_A/Load_B traffic) and a host/loader port used for program data preload and debug readback.
- Valid/ready-style request/grant on each side; one memory access issued per cycle.
- Round-robin fairness, with an optional bounded host lock for bursts.
- Sits between the control unit's D_addr/D_wr path and the data memory instance.

Parameters:
- ADDR_W, 8, data memory address width.
- DATA_W, 16, data word width.
- MAX_LOCK, 4, maximum consecutive host grants while host_lock=1 and the CPU is waiting (range 1..15).

Ports:
- Clk  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with command until granted.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; the control unit holds its state while high.
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host command, same rules as CPU.
- host_lock  in  1  host requests burst priority.
- host_gnt, host_rvalid, host_rdata  out  1/1/DATA_W  host handshake and response.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wr  out  1  registered memory write enable.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr (synchronous RAM).

Behaviour:
- Reset (async, ResetN=0):
  - mem_addr=0, mem_wr=0, mem_wdata=0.
  - cpu_rvalid=0, host_rvalid=0; rdata outputs are 0 when not valid.
  - last_owner=OWN_HOST, so the CPU wins the first tie.
  - lock_cnt=0.
  - In-flight reads are discarded: no rvalid after reset release.
- Grants are combinational from the req inputs and registered state.
  - At most one gnt is high per cycle.
  - A transaction is accepted at the rising edge where req&gnt=1.
  - The requester may change its command or present the next request in the following cycle, giving a throughput of 1 access/cycle.
- Arbitration (evaluated each cycle):
  - Only one req high: grant it.
  - Both high, host_lock=0: grant the side opposite last_owner.
  - Both high, host_lock=1, lock_cnt<MAX_LOCK: grant host.
  - Both high, host_lock=1, lock_cnt==MAX_LOCK: grant CPU.
  - Neither high: no grant; last_owner is unchanged.
- lock_cnt:
  - Increments on an accepted host access while cpu_req=1 and host_lock=1.
  - Clears on any CPU acceptance, or when host_lock=0.
  - Saturates at MAX_LOCK.
  - Host grants while the CPU is idle do not count.
- Pipeline, for a request accepted at the edge ending cycle T:
  - Cycle T+1: mem_addr/mem_wdata are driven from the accepted command; mem_wr=we.
  - Read accepted in T: the owner's rvalid=1 in T+2 with rdata=mem_rdata; the other side's rvalid=0.
  - Write: no response.
  - Owner tags are pipelined 2 deep so back-to-back reads from alternating owners route correctly.
- With no access accepted, mem_wr=0 in the next cycle and mem_addr holds its last value.
- A write followed by a read of the same address in the next cycle returns the new data; memory write-first timing is sufficient, so there is no forwarding logic.
- Reset asserted mid-pipeline clears the tags immediately; the arbiter restarts from the reset state on release.

Decomposition:
- Add to StateDefs package: enum ArbOwner {OWN_NONE, OWN_CPU, OWN_HOST} (2-bit).
- Add to StateDefs package: function owner_to_string for bench display.
- One sub-module, arb_resp_pipe: the 2-stage owner/valid tag pipeline plus rdata steering.
- Grant logic and lock_cnt stay in dmem_arbiter.

Test Plan:
- Reset, then CPU read addr 8'h10 with mem holding 16'hBEEF:
  - cpu_gnt=1 in the request cycle.
  - mem_addr=8'h10 next cycle.
  - cpu_rvalid=1, cpu_rdata=16'hBEEF two cycles after acceptance.
- Both sides request reads the cycle after reset:
  - CPU granted first, host next cycle.
  - Alternation continues CPU/host/CPU over 4 cycles.
  - Each rvalid goes to the correct side with the correct data.
- host_lock=1 with continuous host and CPU requests, MAX_LOCK=4:
  - Grant sequence is H,H,H,H,C,H,H,H,H,C.
  - cpu_stall is high on the 4 host-grant cycles.
- Host writes 16'h1234 to 8'h20, then CPU reads 8'h20 back-to-back:
  - mem_wr=1 for one cycle.
  - cpu_rdata=16'h1234.
  - host_rvalid stays 0.
- ResetN pulsed low one cycle after a CPU read is accepted:
  - All outputs go to reset values immediately.
  - No cpu_rvalid appears after release.
  - The next tie grants the CPU.
- Idle cycles, no requests:
  - mem_wr=0, both gnt=0.
  - last_owner unchanged (checked via the next tie outcome).

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared owner type and helpers for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int LOCK_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } ArbOwner;

  function automatic string owner_to_string(input ArbOwner owner);
    case (owner)
      OWN_CPU:  return "CPU";
      OWN_HOST: return "HOST";
      default:  return "NONE";
    endcase
  endfunction

endpackage

// File: rtl/arb_resp_pipe.sv
// rtl/arb_resp_pipe.sv - two-deep read-owner tag pipeline that steers memory read data
module arb_resp_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  ArbOwner           issue_owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  ArbOwner tag_q1;
  ArbOwner tag_q2;

  // Stage 1 lines up with mem_addr, stage 2 with the RAM's registered read data.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      tag_q1 <= OWN_NONE;
      tag_q2 <= OWN_NONE;
    end else begin
      tag_q1 <= issue_owner;
      tag_q2 <= tag_q1;
    end
  end

  assign cpu_rvalid  = (tag_q2 == OWN_CPU);
  assign host_rvalid = (tag_q2 == OWN_HOST);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin CPU/host arbiter for the single-port data memory
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  ArbOwner             last_owner;
  ArbOwner             issue_owner;
  logic [LOCK_W-1:0]   lock_cnt;
  logic                lock_full;

  assign lock_full = (lock_cnt >= LOCK_W'(MAX_LOCK));

  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (cpu_req && host_req) begin
      if (host_lock) begin
        host_gnt = !lock_full;
        cpu_gnt  = lock_full;
      end else if (last_owner == OWN_CPU) begin
        host_gnt = 1'b1;
      end else begin
        cpu_gnt = 1'b1;
      end
    end else begin
      cpu_gnt  = cpu_req;
      host_gnt = host_req;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    issue_owner = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      issue_owner = OWN_CPU;
    end else if (host_gnt && !host_we) begin
      issue_owner = OWN_HOST;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      last_owner <= OWN_HOST;
      lock_cnt   <= '0;
      mem_addr   <= '0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      mem_wr <= 1'b0;
      if (cpu_gnt) begin
        last_owner <= OWN_CPU;
        mem_addr   <= cpu_addr;
        mem_wdata  <= cpu_wdata;
        mem_wr     <= cpu_we;
      end else if (host_gnt) begin
        last_owner <= OWN_HOST;
        mem_addr   <= host_addr;
        mem_wdata  <= host_wdata;
        mem_wr     <= host_we;
      end
      // Only host wins that actually kept a waiting CPU out count toward the lock budget.
      if (cpu_gnt || !host_lock) begin
        lock_cnt <= '0;
      end else if (host_gnt && cpu_req && !lock_full) begin
        lock_cnt <= lock_cnt + LOCK_W'(1);
      end
    end
  end

  arb_resp_pipe #(
    .DATA_W(DATA_W)
  ) u_resp_pipe (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .issue_owner(issue_owner),
    .mem_rdata  (mem_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a reference model
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int ML = 4;

  logic          Clk = 1'b0;
  logic          ResetN = 1'b0;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous write-first RAM with a bench-side preload port.
  logic [DW-1:0] ram [0:255];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge Clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_wr) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_wr ? mem_wdata : ram[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    int       due;
    bit       side;
    bit [15:0] data;
  } resp_t;

  typedef struct {
    bit cr;
    bit hr;
    bit hl;
    bit ec;
    bit eh;
  } vec_t;

  // Reference model: who went last, how many locked host wins, expected memory contents.
  bit [15:0] shadow [0:255];
  resp_t     resp_q[$];
  int        cyc = 0;
  bit        m_last_host;
  int        m_lock;
  bit [7:0]  m_addr;
  bit [15:0] m_wd;
  bit        m_wr;

  logic          s_cpu_gnt, s_host_gnt, s_cpu_stall, s_mem_wr, s_cpu_rvalid, s_host_rvalid;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_cpu_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    cpu_req = 0; host_req = 0; host_lock = 0; cpu_we = 0; host_we = 0;
    ResetN = 1'b0;
    #1;
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_host_rvalid", 32'(host_rvalid), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_host_rdata", 32'(host_rdata), 0);
    resp_q.delete();
    m_last_host = 1; m_lock = 0; m_addr = 0; m_wd = 0; m_wr = 0;
    @(posedge Clk); #1;
    ResetN = 1'b1;
    cyc++;
  endtask

  task automatic step(input bit cr, input bit cw, input bit [7:0] ca, input bit [15:0] cd,
                      input bit hr, input bit hw, input bit [7:0] ha, input bit [15:0] hd,
                      input bit hl);
    bit eg_c, eg_h, ev_c, ev_h;
    bit [15:0] ed;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
    eg_c = 0; eg_h = 0;
    if (cr && hr) begin
      if (hl) begin
        if (m_lock < ML) eg_h = 1; else eg_c = 1;
      end else if (m_last_host) eg_c = 1;
      else eg_h = 1;
    end else begin
      eg_c = cr; eg_h = hr;
    end
    ev_c = 0; ev_h = 0; ed = 0;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      resp_t r = resp_q.pop_front();
      ed = r.data;
      if (r.side) ev_h = 1; else ev_c = 1;
    end
    @(negedge Clk);
    s_cpu_gnt = cpu_gnt; s_host_gnt = host_gnt; s_cpu_stall = cpu_stall;
    s_mem_wr = mem_wr; s_mem_addr = mem_addr; s_cpu_rvalid = cpu_rvalid;
    s_host_rvalid = host_rvalid; s_cpu_rdata = cpu_rdata;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
    chk("host_gnt", 32'(host_gnt), 32'(eg_h));
    chk("cpu_stall", 32'(cpu_stall), 32'(cr & ~eg_c));
    chk("mem_wr", 32'(mem_wr), 32'(m_wr));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ev_c));
    chk("host_rvalid", 32'(host_rvalid), 32'(ev_h));
    chk("cpu_rdata", 32'(cpu_rdata), ev_c ? 32'(ed) : 0);
    chk("host_rdata", 32'(host_rdata), ev_h ? 32'(ed) : 0);
    m_wr = 0;
    if (eg_c || eg_h) begin
      m_addr = eg_c ? ca : ha;
      m_wd   = eg_c ? cd : hd;
      m_wr   = eg_c ? cw : hw;
      m_last_host = eg_h;
      if (m_wr) shadow[m_addr] = m_wd;
      else resp_q.push_back('{cyc + 2, eg_h, shadow[m_addr]});
    end
    if (eg_c || !hl) m_lock = 0;
    else if (eg_h && cr && m_lock < ML) m_lock++;
    @(posedge Clk); #1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t tbl[14];

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i] = '{1'b1, 1'b1, 1'b1, (i == 4 || i == 9), !(i == 4 || i == 9)};
    end
    for (int i = 10; i < 13; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
    for (int i = 0; i < 256; i++) shadow[i] = 0;

    // Preload addresses 0..31 while held in reset.
    @(posedge Clk); #1;
    pre_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      pre_addr = 8'(i);
      pre_data = (i == 16) ? 16'hBEEF : 16'($urandom);
      shadow[i] = pre_data;
      @(posedge Clk); #1;
    end
    pre_en = 1'b0;
    do_reset();

    // CPU read of a preloaded word.
    step(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    chk("beef_gnt", 32'(s_cpu_gnt), 1);
    idle();
    chk("beef_mem_addr", 32'(s_mem_addr), 32'h10);
    idle();
    chk("beef_rvalid", 32'(s_cpu_rvalid), 1);
    chk("beef_rdata", 32'(s_cpu_rdata), 32'hBEEF);

    // Simultaneous reads straight out of reset alternate starting with the CPU.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'(i), 0, 1, 0, 8'(i + 8), 0, 0);
      chk("alt_cpu_gnt", 32'(s_cpu_gnt), 32'(i % 2 == 0));
      chk("alt_host_gnt", 32'(s_host_gnt), 32'(i % 2 == 1));
    end
    idle();
    idle();

    // Locked burst, idle gap, then a tie resolved from the remembered owner.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].cr, 0, 8'(i), 0, tbl[i].hr, 0, 8'(i + 1), 0, tbl[i].hl);
      chk("tbl_cpu_gnt", 32'(s_cpu_gnt), 32'(tbl[i].ec));
      chk("tbl_host_gnt", 32'(s_host_gnt), 32'(tbl[i].eh));
      chk("tbl_cpu_stall", 32'(s_cpu_stall), 32'(tbl[i].cr & ~tbl[i].ec));
    end
    idle();
    idle();

    // Host write followed immediately by a CPU read of the same word.
    step(0, 0, 0, 0, 1, 1, 8'h20, 16'h1234, 0);
    chk("wr_host_gnt", 32'(s_host_gnt), 1);
    step(1, 0, 8'h20, 0, 0, 0, 0, 0, 0);
    chk("wr_mem_wr", 32'(s_mem_wr), 1);
    chk("wr_mem_addr", 32'(s_mem_addr), 32'h20);
    idle();
    chk("wr_mem_wr_once", 32'(s_mem_wr), 0);
    idle();
    chk("wr_rb_rvalid", 32'(s_cpu_rvalid), 1);
    chk("wr_rb_rdata", 32'(s_cpu_rdata), 32'h1234);
    chk("wr_host_rvalid", 32'(s_host_rvalid), 0);

    // Reset one cycle after a CPU read is accepted drops the response.
    step(1, 0, 8'h05, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rst_no_rvalid", 32'(s_cpu_rvalid), 0);
    end
    step(1, 0, 8'h06, 0, 1, 0, 8'h07, 0, 0);
    chk("rst_tie_cpu", 32'(s_cpu_gnt), 1);
    idle();
    idle();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) == 0, 8'($urandom % 32), 16'($urandom),
           ($urandom % 4) != 0, ($urandom % 3) == 0, 8'($urandom % 32), 16'($urandom),
           ($urandom % 3) == 0);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
